// File: rtl/lock_operation_ctrl.sv
// Operating-mode controller for the digital lock: PIN check, bolt drive,
// auto-lock / door-beep / lockout timers and the setup-block handshake.
module lock_operation_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned LOCKOUT_S     = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pin_valid,
  input  logic [15:0] i_pin_code,
  input  logic        i_setup_key,
  input  logic        i_door_open,
  input  logic [63:0] i_pin_table,
  input  logic [2:0]  i_cfg_pin_en,
  input  logic        i_cfg_bip_on,
  input  logic [6:0]  i_cfg_bip_time,
  input  logic [6:0]  i_cfg_lock_time,
  input  logic        i_setup_end,
  output logic        o_setup_on,
  output logic        o_lock_engaged,
  output logic        o_bip,
  output logic        o_lockout_active,
  output logic        o_intrusion,
  output logic        o_disp_sel,
  output logic [6:0]  o_time_left
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned TW = 7;
  localparam int unsigned FW = 3;

  typedef enum logic [2:0] {
    S_LOCKED    = 3'd0,
    S_UNLOCKED  = 3'd1,
    S_DOOR_OPEN = 3'd2,
    S_LOCKOUT   = 3'd3,
    S_SETUP_REQ = 3'd4,
    S_SETUP_ACK = 3'd5
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [TW-1:0]   r_timer;
  logic [FW-1:0]   r_fail_cnt;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_presc_nxt;
  logic [TW-1:0]   w_timer_nxt;
  logic [FW-1:0]   w_fail_nxt;
  logic [FW-1:0]   w_fail_inc;
  logic            w_load;
  logic            w_sec_tick;
  logic            w_digits_ok;
  logic            w_hit;
  logic            w_match;
  logic [3:0]      w_entry_en;

  function automatic logic [TW-1:0] clamp_cfg(input logic [TW-1:0] v);
    if (v < 7'd5)       return 7'd5;
    else if (v > 7'd60) return 7'd60;
    else                return v;
  endfunction

  assign w_sec_tick = (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_entry_en = {i_cfg_pin_en, 1'b1};
  assign w_fail_inc = r_fail_cnt + FW'(1);

  // Blank/non-decimal digits can never match, even against an equal table entry
  always_comb begin
    w_digits_ok = 1'b1;
    w_hit       = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (i_pin_code[d*4 +: 4] > 4'd9) w_digits_ok = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      if (w_entry_en[p] && (i_pin_table[(3-p)*16 +: 16] == i_pin_code)) w_hit = 1'b1;
    end
    w_match = w_digits_ok & w_hit;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_cnt;
    w_load      = 1'b0;
    w_timer_nxt = (w_sec_tick && (r_timer != '0)) ? r_timer - TW'(1) : r_timer;
    case (r_state)
      S_LOCKED: begin
        if (i_pin_valid) begin
          if (w_match) begin
            w_state_nxt = S_UNLOCKED;
            w_fail_nxt  = '0;
            w_load      = 1'b1;
            w_timer_nxt = clamp_cfg(i_cfg_lock_time);
          end else if (w_fail_inc == FW'(MAX_FAILS)) begin
            w_state_nxt = S_LOCKOUT;
            w_fail_nxt  = '0;
            w_load      = 1'b1;
            w_timer_nxt = TW'(LOCKOUT_S);
          end else begin
            w_fail_nxt  = w_fail_inc;
          end
        end
      end
      S_UNLOCKED: begin
        if (i_door_open) begin
          w_state_nxt = S_DOOR_OPEN;
          w_load      = 1'b1;
          w_timer_nxt = clamp_cfg(i_cfg_bip_time);
        end else if (r_timer == '0) begin
          w_state_nxt = S_LOCKED;
        end else if (i_setup_key) begin
          w_state_nxt = S_SETUP_REQ;
        end
      end
      S_DOOR_OPEN: begin
        if (!i_door_open) begin
          w_state_nxt = S_UNLOCKED;
          w_load      = 1'b1;
          w_timer_nxt = clamp_cfg(i_cfg_lock_time);
        end
      end
      S_LOCKOUT:   if (r_timer == '0) w_state_nxt = S_LOCKED;
      S_SETUP_REQ: if (!i_setup_end)  w_state_nxt = S_SETUP_ACK;
      S_SETUP_ACK: if (i_setup_end)   w_state_nxt = S_LOCKED;
      default:     w_state_nxt = S_LOCKED;
    endcase
    if (!(w_state_nxt inside {S_UNLOCKED, S_DOOR_OPEN, S_LOCKOUT})) w_timer_nxt = '0;
    w_presc_nxt = (w_load || w_sec_tick) ? '0 : r_presc + PW'(1);
  end

  // Outputs are registered from the next-state values so they line up with r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_LOCKED;
      r_presc          <= '0;
      r_timer          <= '0;
      r_fail_cnt       <= '0;
      o_setup_on       <= 1'b0;
      o_lock_engaged   <= 1'b1;
      o_bip            <= 1'b0;
      o_lockout_active <= 1'b0;
      o_intrusion      <= 1'b0;
      o_disp_sel       <= 1'b0;
      o_time_left      <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_presc          <= w_presc_nxt;
      r_timer          <= w_timer_nxt;
      r_fail_cnt       <= w_fail_nxt;
      o_setup_on       <= (w_state_nxt == S_SETUP_REQ);
      o_lock_engaged   <= (w_state_nxt inside {S_LOCKED, S_LOCKOUT});
      o_bip            <= (w_state_nxt == S_DOOR_OPEN) && (w_timer_nxt == '0) && i_cfg_bip_on;
      o_lockout_active <= (w_state_nxt == S_LOCKOUT);
      o_intrusion      <= i_door_open && (w_state_nxt inside {S_LOCKED, S_LOCKOUT});
      o_disp_sel       <= (w_state_nxt inside {S_SETUP_REQ, S_SETUP_ACK});
      o_time_left      <= w_timer_nxt;
    end
  end

endmodule

// File: tb/tb_lock_operation_ctrl.sv
// Bench for lock_operation_ctrl: directed scenarios plus random traffic,
// compared each cycle against a time-since-entry reference model.
module tb_lock_operation_ctrl;

  localparam int TPS       = 4;
  localparam int MAX_FAILS = 3;
  localparam int LOCKOUT_S = 30;

  logic        clk, rst;
  logic        pin_valid, setup_key, door_open, cfg_bip_on, setup_end;
  logic [15:0] pin_code;
  logic [63:0] pin_table;
  logic [2:0]  cfg_pin_en;
  logic [6:0]  cfg_bip_time, cfg_lock_time;
  logic        setup_on, lock_engaged, bip, lockout_active, intrusion, disp_sel;
  logic [6:0]  time_left;

  int n_cmp = 0;
  int n_err = 0;

  lock_operation_ctrl #(.TICKS_PER_SEC(TPS), .MAX_FAILS(MAX_FAILS), .LOCKOUT_S(LOCKOUT_S)) dut (
    .clk(clk), .rst(rst),
    .i_pin_valid(pin_valid), .i_pin_code(pin_code), .i_setup_key(setup_key),
    .i_door_open(door_open), .i_pin_table(pin_table), .i_cfg_pin_en(cfg_pin_en),
    .i_cfg_bip_on(cfg_bip_on), .i_cfg_bip_time(cfg_bip_time),
    .i_cfg_lock_time(cfg_lock_time), .i_setup_end(setup_end),
    .o_setup_on(setup_on), .o_lock_engaged(lock_engaged), .o_bip(bip),
    .o_lockout_active(lockout_active), .o_intrusion(intrusion),
    .o_disp_sel(disp_sel), .o_time_left(time_left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode plus the edge at which the current countdown was loaded
  typedef enum int {M_LOCKED, M_UNLOCKED, M_DOOR, M_LOCKOUT, M_SREQ, M_SACK} mode_t;
  mode_t m_mode;
  int    m_fails, m_edge, m_entry, m_load;

  function automatic int remaining(input int n);
    int r;
    r = m_load - (n - m_entry) / TPS;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int clamp_sec(input int v);
    return (v < 5) ? 5 : ((v > 60) ? 60 : v);
  endfunction

  function automatic bit pin_matches();
    bit found = 0;
    for (int d = 0; d < 4; d++) if (((int'(pin_code) >> (4*d)) & 15) > 9) return 0;
    for (int p = 0; p < 4; p++) begin
      bit en = (p == 0) ? 1'b1 : cfg_pin_en[p-1];
      logic [63:0] sh = pin_table >> (16*(3-p));
      if (en && (sh[15:0] == pin_code)) found = 1;
    end
    return found;
  endfunction

  task automatic model_reset();
    m_mode = M_LOCKED; m_fails = 0; m_edge = 0; m_entry = 0; m_load = 0;
  endtask

  task automatic enter(input mode_t m, input int secs);
    m_mode = m; m_entry = m_edge; m_load = secs;
  endtask

  task automatic model_step();
    int old_rem;
    m_edge++;
    old_rem = remaining(m_edge - 1);
    case (m_mode)
      M_LOCKED: if (pin_valid) begin
        if (pin_matches()) begin
          m_fails = 0; enter(M_UNLOCKED, clamp_sec(int'(cfg_lock_time)));
        end else begin
          m_fails++;
          if (m_fails == MAX_FAILS) begin
            m_fails = 0; enter(M_LOCKOUT, LOCKOUT_S);
          end
        end
      end
      M_UNLOCKED: begin
        if (door_open)         enter(M_DOOR, clamp_sec(int'(cfg_bip_time)));
        else if (old_rem == 0) m_mode = M_LOCKED;
        else if (setup_key)    m_mode = M_SREQ;
      end
      M_DOOR:    if (!door_open) enter(M_UNLOCKED, clamp_sec(int'(cfg_lock_time)));
      M_LOCKOUT: if (old_rem == 0) m_mode = M_LOCKED;
      M_SREQ:    if (!setup_end) m_mode = M_SACK;
      M_SACK:    if (setup_end)  m_mode = M_LOCKED;
      default:   m_mode = M_LOCKED;
    endcase
  endtask

  task automatic check_all();
    bit locked_like = (m_mode == M_LOCKED) || (m_mode == M_LOCKOUT);
    bit timed = (m_mode == M_UNLOCKED) || (m_mode == M_DOOR) || (m_mode == M_LOCKOUT);
    int rem = timed ? remaining(m_edge) : 0;
    chk("lock_engaged",   32'(lock_engaged),   32'(locked_like));
    chk("lockout_active", 32'(lockout_active), 32'(m_mode == M_LOCKOUT));
    chk("setup_on",       32'(setup_on),       32'(m_mode == M_SREQ));
    chk("disp_sel",       32'(disp_sel),       32'((m_mode == M_SREQ) || (m_mode == M_SACK)));
    chk("time_left",      32'(time_left),      32'(rem));
    chk("bip",            32'(bip),            32'((m_mode == M_DOOR) && (rem == 0) && cfg_bip_on));
    chk("intrusion",      32'(intrusion),      32'(door_open && locked_like));
  endtask

  // One clock: inputs already set at the preceding negedge; pulses drop afterwards
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1 check_all();
      @(negedge clk);
      pin_valid = 1'b0;
      setup_key = 1'b0;
    end
  endtask

  task automatic enter_pin(input logic [15:0] code);
    pin_code = code; pin_valid = 1'b1;
    tick();
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_setup_on"},  32'(setup_on),       32'(0));
    chk({tag, "_lockout"},   32'(lockout_active), 32'(0));
    chk({tag, "_lock"},      32'(lock_engaged),   32'(1));
    chk({tag, "_time_left"}, 32'(time_left),      32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pin_valid = 1'b0; setup_key = 1'b0; door_open = 1'b0; setup_end = 1'b1;
    pin_code = 16'h0000; pin_table = {16'h1234, 16'h5678, 16'h0042, 16'h12B4};
    cfg_pin_en = 3'b000; cfg_bip_on = 1'b1; cfg_bip_time = 7'd2; cfg_lock_time = 7'd10;
    #1 rst = 1'b1;
    #1;
    chk("rst_lock", 32'(lock_engaged), 32'(1));
    chk("rst_setup_on", 32'(setup_on), 32'(0));
    chk("rst_time_left", 32'(time_left), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Correct PIN then auto-lock after 10 s
    enter_pin(16'h1234);
    chk("t1_unlock", 32'(lock_engaged), 32'(0));
    chk("t1_time_start", 32'(time_left), 32'(10));
    tick(10*TPS);
    chk("t1_time_zero", 32'(time_left), 32'(0));
    chk("t1_still_open", 32'(lock_engaged), 32'(0));
    tick();
    chk("t1_relock", 32'(lock_engaged), 32'(1));

    // Disabled PIN counts as wrong; third miss starts lockout
    enter_pin(16'h5678);
    enter_pin(16'h5678);
    chk("t2_locked", 32'(lock_engaged), 32'(1));
    enter_pin(16'h5678);
    chk("t2_lockout", 32'(lockout_active), 32'(1));
    chk("t2_time", 32'(time_left), 32'(30));
    enter_pin(16'h1234);
    chk("t2_ignored", 32'(lock_engaged), 32'(1));
    tick(LOCKOUT_S*TPS - 1);
    chk("t2_last", 32'(lockout_active), 32'(1));
    tick();
    chk("t2_done", 32'(lockout_active), 32'(0));

    // Door-open beep with clamped bip time
    enter_pin(16'h1234);
    door_open = 1'b1;
    tick();
    chk("t3_door_time", 32'(time_left), 32'(5));
    tick(5*TPS - 1);
    chk("t3_no_bip", 32'(bip), 32'(0));
    tick();
    chk("t3_bip", 32'(bip), 32'(1));
    door_open = 1'b0;
    tick();
    chk("t3_bip_off", 32'(bip), 32'(0));
    chk("t3_reload", 32'(time_left), 32'(10));

    // Setup handshake
    setup_key = 1'b1;
    tick();
    chk("t4_setup_on", 32'(setup_on), 32'(1));
    chk("t4_disp", 32'(disp_sel), 32'(1));
    setup_end = 1'b0;
    tick();
    chk("t4_ack", 32'(setup_on), 32'(0));
    setup_end = 1'b1;
    tick();
    chk("t4_locked", 32'(lock_engaged), 32'(1));
    chk("t4_disp_off", 32'(disp_sel), 32'(0));

    // Intrusion and blank digit
    door_open = 1'b1;
    tick();
    chk("t5_intrusion", 32'(intrusion), 32'(1));
    door_open = 1'b0;
    tick();
    chk("t5_clear", 32'(intrusion), 32'(0));
    cfg_pin_en = 3'b111;
    enter_pin(16'h12B4);
    chk("t5_blank", 32'(lock_engaged), 32'(1));
    cfg_pin_en = 3'b001;
    enter_pin(16'h5678);
    chk("t5_pin2", 32'(lock_engaged), 32'(0));
    tick(10*TPS + 1);

    // Async reset mid-setup and mid-lockout
    enter_pin(16'h1234);
    setup_key = 1'b1;
    tick();
    chk("t6_in_setup", 32'(setup_on), 32'(1));
    do_reset("t6a");
    enter_pin(16'h9999);
    enter_pin(16'h9999);
    enter_pin(16'h9999);
    tick(5);
    chk("t6_in_lockout", 32'(lockout_active), 32'(1));
    do_reset("t6b");

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        cfg_pin_en    = 3'($urandom);
        cfg_bip_on    = 1'($urandom);
        cfg_bip_time  = 7'($urandom_range(0, 127));
        cfg_lock_time = 7'($urandom_range(0, 127));
      end
      pin_valid = ($urandom % 6 == 0);
      case ($urandom % 4)
        0, 1: begin
          logic [63:0] sh = pin_table >> (16 * ($urandom % 4));
          pin_code = sh[15:0];
        end
        2: pin_code = {4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10)};
        default: pin_code = 16'($urandom);
      endcase
      setup_key = ($urandom % 8 == 0);
      if ($urandom % 30 == 0) door_open = ~door_open;
      if ($urandom % 6 == 0)  setup_end = ~setup_end;
      tick();
      if (c % 1300 == 1299) do_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lock_operation_ctrl.md
Name: lock_operation_ctrl

Overview:
Top-level operating-mode controller for the digital lock. It checks entered PINs against the configured PIN table and drives the lock actuator. It runs the auto-lock, door-open beep and lockout timers. It sequences the setup block through its setup_on / setup_end handshake and selects which source owns the BCD display.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per one-second timer tick
MAX_FAILS, 3, consecutive wrong PINs that trigger lockout (1..7)
LOCKOUT_S, 30, lockout duration in seconds (1..127)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pin_valid  in  1  one-cycle pulse, pin_code holds a complete entry
pin_code  in  16  entered PIN, 4 BCD digits, [15:12] first digit
setup_key  in  1  one-cycle pulse, request setup mode
door_open  in  1  door sensor level, 1 = open
pin_table  in  64  pin1..pin4, 16 bits each, pin1 at [63:48]
cfg_pin_en  in  3  enable for pin2..pin4, bit0 = pin2; pin1 is always enabled
cfg_bip_on  in  1  beep enable
cfg_bip_time  in  7  seconds the door may stay open before beeping
cfg_lock_time  in  7  auto-lock seconds
setup_end  in  1  from setup block, idles 1, low while setup reports completion
setup_on  out  1  request to setup block
lock_engaged  out  1  1 = bolt locked
bip  out  1  beeper drive
lockout_active  out  1  lockout in progress
intrusion  out  1  door opened while locked or in lockout
disp_sel  out  1  0 = operating display, 1 = setup block owns BCD display
time_left  out  7  current countdown value for display

Behaviour:
- Reset values: state LOCKED, lock_engaged=1, all other outputs 0, fail_cnt=0, timer=0, prescaler=0.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1; sec_tick pulses on wrap.
  - Cleared on every entry to a timed state, so the first decrement comes a full second after entry.
- Timer:
  - 7-bit. Decrements on sec_tick and saturates at 0.
  - time_left mirrors the timer in timed states and is 0 otherwise.
- Config clamp: cfg_bip_time and cfg_lock_time values below 5 are used as 5; values above 60 are used as 60. Values are sampled only when the timer is loaded.
- PIN match:
  - Combinational equality of pin_code against each enabled table entry.
  - Any nibble >9 in pin_code (e.g. 0xB blank) forces no-match.
  - The state update happens on the next clk edge (1-cycle latency).
- LOCKED:
  - pin_valid with a match -> UNLOCKED, fail_cnt=0.
  - pin_valid with a miss -> fail_cnt+1. If the new count equals MAX_FAILS -> LOCKOUT, timer=LOCKOUT_S, fail_cnt=0.
  - door_open=1 -> intrusion=1, state unchanged.
  - setup_key is ignored.
- UNLOCKED:
  - lock_engaged=0; on entry, timer=clamped cfg_lock_time.
  - door_open -> DOOR_OPEN.
  - Timer reaching 0 -> LOCKED.
  - setup_key while door closed -> SETUP_REQ.
  - pin_valid is ignored.
  - If setup_key and door_open arrive in the same cycle, door_open wins.
- DOOR_OPEN:
  - lock_engaged=0; on entry, timer=clamped cfg_bip_time.
  - When the timer hits 0: bip=cfg_bip_on, held until the door closes.
  - door_open=0 -> UNLOCKED (auto-lock timer reloads), bip=0.
- LOCKOUT:
  - lock_engaged=1, lockout_active=1.
  - pin_valid and setup_key are ignored.
  - Timer reaching 0 -> LOCKED, lockout_active=0.
  - door_open -> intrusion=1.
- intrusion: cleared on the cycle after door_open=0.
- SETUP_REQ:
  - setup_on=1, disp_sel=1, lock_engaged=0.
  - setup_end=0 -> SETUP_ACK.
- SETUP_ACK:
  - setup_on=0, disp_sel=1.
  - setup_end=1 -> LOCKED, disp_sel=0.
- Setup handshake: there is no timeout; only rst aborts the handshake. Config inputs are not sampled during setup.
- Reset mid-operation: all outputs return to their reset values immediately (async). A setup block reset by the same rst sees setup_on=0.
- Unreachable state encodings -> LOCKED.

Test Plan:
1. Correct PIN: pin_table pin1=0x1234, pin_valid with 0x1234 -> lock_engaged=0 one cycle later. Door stays closed, cfg_lock_time=10 -> lock_engaged=1 after 10 sec_ticks, time_left counts 10..0.
2. Disabled PIN and lockout: pin2=0x5678 with cfg_pin_en=0, MAX_FAILS=3; enter 0x5678 three times -> stays locked, then lockout_active=1, time_left=30. A correct PIN during lockout is ignored; after 30 ticks -> LOCKED, fail_cnt=0.
3. Door-open beep: unlock, raise door_open, cfg_bip_time=2 (clamped to 5), cfg_bip_on=1 -> bip=1 after 5 ticks. Close the door -> bip=0 and the auto-lock timer reloads.
4. Setup handshake: unlocked with door closed, setup_key -> setup_on=1, disp_sel=1. Drive setup_end=0 -> setup_on=0. Drive setup_end=1 -> LOCKED, disp_sel=0.
5. Intrusion and blank digits: door_open while LOCKED -> intrusion=1, lock_engaged=1. pin_code=0x12B4 never matches even if a table entry equals 0x12B4.
6. Async reset: assert rst mid-SETUP_REQ and mid-LOCKOUT -> setup_on=0, lockout_active=0, lock_engaged=1 without waiting for a clk edge.
